// File: rtl/secuenciador_pkg.sv
// Shared definitions for the sequencer: ALU opcodes, FSM states and
// instruction field positions.
package secuenciador_pkg;

  localparam logic [2:0] OP_SUM  = 3'd0;
  localparam logic [2:0] OP_COMP = 3'd1;
  localparam logic [2:0] OP_SL   = 3'd2;
  localparam logic [2:0] OP_SR   = 3'd3;
  localparam logic [2:0] OP_CMI  = 3'd4;
  localparam logic [2:0] OP_CMM  = 3'd5;
  localparam logic [2:0] OP_SA   = 3'd6;
  localparam logic [2:0] OP_LO   = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WB,
    S_DONE
  } state_t;

  localparam int OPC_HI = 7;
  localparam int OPC_LO = 5;
  localparam int RA_HI  = 4;
  localparam int RA_LO  = 3;
  localparam int RB_HI  = 2;
  localparam int RB_LO  = 1;
  localparam int WB_BIT = 0;

  // SA and LO leave dato_mux untouched, so there is nothing to write back.
  function automatic logic wb_allowed(input logic [7:0] ins);
    return ins[WB_BIT] && (ins[OPC_HI:OPC_LO] != OP_SA) &&
           (ins[OPC_HI:OPC_LO] != OP_LO);
  endfunction

endpackage

// File: rtl/secuenciador_banco_registros.sv
// 4x4-bit register file: one shared write port, three combinational reads
// (ALU operand A, operand B, debug).
module banco_registros (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [1:0] wsel,
  input  logic [3:0] wdata,
  input  logic [1:0] sel_a,
  input  logic [1:0] sel_b,
  input  logic [1:0] sel_d,
  output logic [3:0] rdata_a,
  output logic [3:0] rdata_b,
  output logic [3:0] rdata_d
);

  logic [3:0] regs [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wsel] <= wdata;
    end
  end

  assign rdata_a = regs[sel_a];
  assign rdata_b = regs[sel_b];
  assign rdata_d = regs[sel_d];

endmodule

// File: rtl/secuenciador.sv
// Instruction sequencer feeding the 4-bit ALU: fetches from a loadable
// program memory, holds ALU operands for ALU_LAT cycles, writes results back.
module secuenciador
  import secuenciador_pkg::*;
#(
  parameter int AW      = 4,
  parameter int ALU_LAT = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [7:0]    load_data,
  input  logic          reg_we,
  input  logic [1:0]    reg_sel,
  input  logic [3:0]    reg_wdata,
  output logic [3:0]    reg_rdata,
  input  logic          start,
  input  logic [AW:0]   prog_len,
  output logic [7:0]    instr,
  output logic [3:0]    A,
  output logic [3:0]    B,
  input  logic [3:0]    dato_mux,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] pc,
  output logic          wb_valid,
  output logic [1:0]    wb_sel,
  output logic [3:0]    wb_data
);

  localparam int              CW      = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CW-1:0]   CNT_END = CW'(ALU_LAT - 1);
  localparam logic [AW:0]     LEN_MAX = (AW+1)'(1 << AW);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [AW:0]   len;
  logic [7:0]    mem [1 << AW];
  logic [7:0]    fetch_word;
  logic          idle;
  logic          wb_fire;
  logic [1:0]    wb_sel_q;
  logic [3:0]    wb_data_q;
  logic [3:0]    rd_a;
  logic [3:0]    rd_b;
  logic          rf_we;
  logic [1:0]    rf_wsel;
  logic [3:0]    rf_wdata;
  logic [AW:0]   len_clamp;
  logic [AW-1:0] pc_inc;
  logic          last_instr;

  assign idle       = (state == S_IDLE) || (state == S_DONE);
  assign fetch_word = mem[pc];
  assign wb_fire    = (state == S_WB) && wb_allowed(instr);
  assign len_clamp  = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
  assign pc_inc     = (pc == {AW{1'b1}}) ? pc : pc + AW'(1);
  assign last_instr = (({1'b0, pc} + (AW+1)'(1)) == len);

  // Presets only happen while idle and writebacks only in WB, so the two never collide.
  assign rf_we    = wb_fire || (reg_we && idle);
  assign rf_wsel  = wb_fire ? instr[RA_HI:RA_LO] : reg_sel;
  assign rf_wdata = wb_fire ? dato_mux : reg_wdata;

  assign wb_valid = wb_fire;
  assign wb_sel   = wb_fire ? instr[RA_HI:RA_LO] : wb_sel_q;
  assign wb_data  = wb_fire ? dato_mux : wb_data_q;

  banco_registros u_regs (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .wsel    (rf_wsel),
    .wdata   (rf_wdata),
    .sel_a   (fetch_word[RA_HI:RA_LO]),
    .sel_b   (fetch_word[RB_HI:RB_LO]),
    .sel_d   (reg_sel),
    .rdata_a (rd_a),
    .rdata_b (rd_b),
    .rdata_d (reg_rdata)
  );

  // Program memory survives reset so a program can be rerun after an abort.
  always_ff @(posedge clk) begin
    if (load_en && idle) mem[load_addr] <= load_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      len       <= '0;
      pc        <= '0;
      instr     <= '0;
      A         <= '0;
      B         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wb_sel_q  <= '0;
      wb_data_q <= '0;
    end else begin
      if (wb_fire) begin
        wb_sel_q  <= instr[RA_HI:RA_LO];
        wb_data_q <= dato_mux;
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            len <= len_clamp;
            pc  <= '0;
            if (prog_len == '0) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_FETCH;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
        end
        S_FETCH: begin
          instr <= fetch_word;
          A     <= rd_a;
          B     <= rd_b;
          cnt   <= '0;
          state <= S_EXEC;
        end
        S_EXEC: begin
          cnt <= cnt + CW'(1);
          if (cnt == CNT_END) state <= S_WB;
        end
        S_WB: begin
          pc <= pc_inc;
          if (last_instr) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= S_FETCH;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
